// File: rtl/if_id_stage_if.sv
// Fetch-to-decode bundle: fetch-side inputs plus the registered and pre-decoded outputs.
interface if_id_stage_if;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic [31:0] pcPlus4_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pcPlus4_o;
    logic        valid_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [4:0]  rd_o;
    logic [31:0] imm_o;
    logic [15:0] bubbles_o;

    // Fetch / environment side.
    modport master (
        output stall_i, flush_i, instr_i, pc_i, pcPlus4_i,
        input  instr_o, pc_o, pcPlus4_o, valid_o, rs1_o, rs2_o, rd_o, imm_o, bubbles_o
    );

    // Pipeline register side.
    modport slave (
        input  stall_i, flush_i, instr_i, pc_i, pcPlus4_i,
        output instr_o, pc_o, pcPlus4_o, valid_o, rs1_o, rs2_o, rd_o, imm_o, bubbles_o
    );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with stall/flush, warm-up discard of the first fetch slot,
// register-index/immediate pre-decode and a saturating bubble counter.
module if_id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    if_id_stage_if.slave  bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // COLD until the first non-stalled edge after reset; that slot is discarded.
    typedef enum logic {ST_COLD, ST_WARM} warm_e;

    warm_e             state_q, state_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   pc4_q, pc4_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  bub_q, bub_d;
    logic [XLEN-1:0]   imm;

    // State and pipeline registers; reset restores the bubble slot and discard state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_COLD;
            instr_q <= NOP_INSTR;
            pc_q    <= RESET_PC;
            pc4_q   <= RESET_PC + XLEN'(4);
            valid_q <= 1'b0;
            bub_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            bub_q   <= bub_d;
        end
    end

    // Next-state: flush beats stall beats capture; a cold capture loads a bubble.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        bub_d   = bub_q;

        if (bus.flush_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            state_d = ST_WARM;
        end else if (!bus.stall_i) begin
            pc_d    = bus.pc_i;
            pc4_d   = bus.pcPlus4_i;
            state_d = ST_WARM;
            if (state_q == ST_WARM) begin
                instr_d = bus.instr_i;
                valid_d = 1'b1;
            end else begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end

        if ((state_q == ST_WARM) && !valid_d && (bub_q != '1)) begin
            bub_d = bub_q + CNT_W'(1);
        end
    end

    // Immediate pre-decode from the registered instruction's opcode.
    always_comb begin
        imm = '0;
        unique case (instr_q[6:0])
            OP_LOAD, OP_IMM, OP_JALR:
                imm = {{20{instr_q[31]}}, instr_q[31:20]};
            OP_STORE:
                imm = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            OP_BRANCH:
                imm = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                       instr_q[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {instr_q[31:12], 12'b0};
            OP_JAL:
                imm = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                       instr_q[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

    assign bus.instr_o   = instr_q;
    assign bus.pc_o      = pc_q;
    assign bus.pcPlus4_o = pc4_q;
    assign bus.valid_o   = valid_q;
    assign bus.rs1_o     = instr_q[19:15];
    assign bus.rs2_o     = instr_q[24:20];
    assign bus.rd_o      = instr_q[11:7];
    assign bus.imm_o     = imm;
    assign bus.bubbles_o = bub_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_if_id_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    bit   check_en = 1'b0;

    if_id_stage_if bus ();

    if_id_stage #(.NOP_INSTR(NOP), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state.
    logic [31:0] m_instr, m_pc, m_pc4;
    bit          m_valid, m_warm;
    int          m_bub;

    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        logic [6:0] op;
        op = i[6:0];
        if (op == 7'b0000011 || op == 7'b0010011 || op == 7'b1100111)
            return {{20{i[31]}}, i[31:20]};
        if (op == 7'b0100011)
            return {{20{i[31]}}, i[31:25], i[11:7]};
        if (op == 7'b1100011)
            return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        if (op == 7'b0110111 || op == 7'b0010111)
            return {i[31:12], 12'b0};
        if (op == 7'b1101111)
            return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        return 32'h0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: apply the slot rules at each edge; reset is asynchronous.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_instr = NOP; m_pc = 32'h0; m_pc4 = 32'h4;
            m_valid = 1'b0; m_warm = 1'b0; m_bub = 0;
        end else begin
            bit was_warm;
            was_warm = m_warm;
            if (bus.flush_i) begin
                m_instr = NOP; m_valid = 1'b0; m_warm = 1'b1;
            end else if (!bus.stall_i) begin
                m_pc  = bus.pc_i;
                m_pc4 = bus.pcPlus4_i;
                m_instr = was_warm ? bus.instr_i : NOP;
                m_valid = was_warm;
                m_warm  = 1'b1;
            end
            if (was_warm && !m_valid && m_bub < 65535) m_bub = m_bub + 1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check("instr",   bus.instr_o,   m_instr);
            check("pc",      bus.pc_o,      m_pc);
            check("pc4",     bus.pcPlus4_o, m_pc4);
            check("valid",   32'(bus.valid_o), 32'(m_valid));
            check("rs1",     32'(bus.rs1_o), 32'(m_instr[19:15]));
            check("rs2",     32'(bus.rs2_o), 32'(m_instr[24:20]));
            check("rd",      32'(bus.rd_o),  32'(m_instr[11:7]));
            check("imm",     bus.imm_o,     ref_imm(m_instr));
            check("bubbles", 32'(bus.bubbles_o), 32'(m_bub));
        end
    end

    task automatic step(input logic s, input logic f, input logic [31:0] ins,
                        input logic [31:0] pc);
        bus.stall_i   = s;
        bus.flush_i   = f;
        bus.instr_i   = ins;
        bus.pc_i      = pc;
        bus.pcPlus4_i = pc + 32'd4;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_instr"}, bus.instr_o, 32'h0000_0013);
        check({tag, "_pc"},    bus.pc_o,    32'h0);
        check({tag, "_pc4"},   bus.pcPlus4_o, 32'h4);
        check({tag, "_valid"}, 32'(bus.valid_o), 32'h0);
        check({tag, "_bub"},   32'(bus.bubbles_o), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        bus.stall_i = 1'($urandom); bus.flush_i = 1'($urandom);
        bus.instr_i = $urandom; bus.pc_i = $urandom; bus.pcPlus4_i = $urandom;

        // Reset with random inputs.
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check_en = 1'b1;
        check_reset_vals("reset");

        // Warm-up: first slot discarded, second captured.
        rst = 1'b0;
        step(1'b0, 1'b0, 32'h0050_0093, $urandom);
        check("warm1_valid", 32'(bus.valid_o), 32'h0);
        check("warm1_instr", bus.instr_o, NOP);
        step(1'b0, 1'b0, 32'h0050_0093, 32'h4);
        check("warm2_valid", 32'(bus.valid_o), 32'h1);
        check("warm2_pc",    bus.pc_o, 32'h4);
        check("warm2_instr", bus.instr_o, 32'h0050_0093);

        // Flow.
        step(1'b0, 1'b0, 32'hFFF0_0093, 32'h8);
        check("flow_imm", bus.imm_o, 32'hFFFF_FFFF);
        check("flow_rd",  32'(bus.rd_o), 32'd1);
        check("flow_pc4", bus.pcPlus4_o, 32'hC);
        step(1'b0, 1'b0, 32'h00C5_8633, 32'hC);
        check("rtype_rs1", 32'(bus.rs1_o), 32'd11);
        check("rtype_rs2", 32'(bus.rs2_o), 32'd12);
        check("rtype_rd",  32'(bus.rd_o),  32'd12);
        check("rtype_imm", bus.imm_o, 32'h0);

        // Stall holds everything while inputs change.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, $urandom, $urandom);
            check("stall_instr", bus.instr_o, 32'h00C5_8633);
            check("stall_pc",    bus.pc_o, 32'hC);
            check("stall_valid", 32'(bus.valid_o), 32'h1);
        end
        step(1'b0, 1'b0, 32'h0011_2223, 32'h10);
        check("resume_instr", bus.instr_o, 32'h0011_2223);
        check("store_imm",    bus.imm_o, 32'h4);

        // Flush and stall together: bubble, pc held, counter +1.
        step(1'b1, 1'b1, 32'h0050_0093, 32'h14);
        check("fs_instr", bus.instr_o, NOP);
        check("fs_valid", 32'(bus.valid_o), 32'h0);
        check("fs_pc",    bus.pc_o, 32'h10);
        check("fs_bub",   32'(bus.bubbles_o), 32'd1);
        step(1'b1, 1'b0, 32'h0050_0093, 32'h14);
        check("stall_bubble_bub", 32'(bus.bubbles_o), 32'd2);

        // Remaining immediate formats.
        step(1'b0, 1'b0, 32'hFE00_0EE3, 32'h18);
        check("b_imm", bus.imm_o, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0080_00EF, 32'h1C);
        check("j_imm", bus.imm_o, 32'h8);
        step(1'b0, 1'b0, 32'h1234_52B7, 32'hFFFF_FFFC);
        check("u_imm", bus.imm_o, 32'h1234_5000);
        check("wrap_pc4", bus.pcPlus4_o, 32'h0);

        // Asynchronous reset between edges while stalled.
        step(1'b1, 1'b0, $urandom, $urandom);
        #2 rst = 1'b1;
        #1 check_reset_vals("async");
        @(negedge clk); #1;
        rst = 1'b0;
        step(1'b0, 1'b0, 32'h0050_0093, $urandom);
        check("rewarm_valid", 32'(bus.valid_o), 32'h0);
        step(1'b0, 1'b0, 32'h0050_0093, 32'h4);
        check("rewarm2_valid", 32'(bus.valid_o), 32'h1);

        // Randomized traffic, compared every cycle by the checker process.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc;
            rst = ($urandom_range(0, 149) == 0);
            pc  = ($urandom_range(0, 31) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            bus.stall_i   = ($urandom_range(0, 99) < 30);
            bus.flush_i   = ($urandom_range(0, 99) < 15);
            bus.instr_i   = $urandom;
            bus.pc_i      = pc;
            bus.pcPlus4_i = ($urandom_range(0, 7) == 0) ? $urandom : pc + 32'd4;
            @(posedge clk);
            @(negedge clk);
            #1;
        end

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
